// File: rtl/ddr_pair_deser.sv
// Dual-edge receive deserializer: pairs the negedge and posedge samples of din
// each cycle and assembles them MSB-first into WORD_W-bit words behind a valid/ready slot.
module ddr_pair_deser #(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  logic              en,
   input  logic              align,
   output logic [WORD_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              overflow
);

   localparam int PAIRS = WORD_W / 2;
   localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAIRS - 1);

   logic              neg_bit_q;
   logic [1:0]        pair;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [WORD_W-1:0] word;
   logic [WORD_W-1:0] dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;
   logic              word_done;
   logic              slot_free;

   // Older half-bit: captured on the falling edge between two posedges.
   always_ff @(negedge clk) begin
      if (rst) neg_bit_q <= 1'b0;
      else     neg_bit_q <= din;
   end

   assign pair = {neg_bit_q, din};

   always_comb begin
      word      = (shift_q << 2) | WORD_W'(pair);
      word_done = !align && en && (cnt_q == CNT_LAST);
      slot_free = !valid_q || dout_ready;

      cnt_d   = cnt_q;
      shift_d = shift_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;

      if (align) begin
         cnt_d   = '0;
         shift_d = '0;
      end else if (en) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            shift_d = '0;
         end else begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = word;
         end
      end

      // A completed word may replace a word being accepted in the same cycle.
      if (word_done) begin
         if (slot_free) begin
            dout_d  = word;
            valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (valid_q && dout_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         shift_q <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_ddr_pair_deser.sv
// Bench for ddr_pair_deser: directed scenarios plus random traffic, checked
// against a bit-list reference model with a scoreboard of accepted words.
module tb_ddr_pair_deser;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         din = 1'b0;
   logic         en = 1'b0;
   logic         align = 1'b0;
   logic         dout_ready = 1'b0;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         overflow;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: bits received so far for the current word, plus output slot.
   bit           m_bits[$];
   logic [W-1:0] m_dout  = '0;
   logic         m_valid = 1'b0;
   logic         m_ovf   = 1'b0;
   logic [W-1:0] sb[$];

   ddr_pair_deser #(.WORD_W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .en         (en),
      .align      (align),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one clock cycle of stimulus; the model is advanced for the upcoming posedge.
   task automatic cyc(input logic nb, input logic pb, input logic e, input logic a,
                      input logic r, input logic rs);
      logic         nb_eff;
      logic [W-1:0] w;
      @(posedge clk);
      #2 din = nb;
      @(negedge clk);
      nb_eff = rst ? 1'b0 : nb;
      #2;
      din = pb; en = e; align = a; dout_ready = r; rst = rs;
      if (rs) begin
         m_bits.delete();
         m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0;
         sb.delete();
      end else if (a) begin
         m_bits.delete();
         if (m_valid && r) m_valid = 1'b0;
      end else if (e) begin
         m_bits.push_back(nb_eff);
         m_bits.push_back(pb);
         if (m_bits.size() == W) begin
            w = '0;
            foreach (m_bits[i]) w = {w[W-2:0], m_bits[i]};
            m_bits.delete();
            if (!m_valid || r) begin
               m_dout = w; m_valid = 1'b1;
               sb.push_back(w);
            end else begin
               m_ovf = 1'b1;
            end
         end else if (m_valid && r) begin
            m_valid = 1'b0;
         end
      end else if (m_valid && r) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic send_word(input logic [7:0] w, input logic r);
      for (int i = 0; i < 4; i++) cyc(w[7-2*i], w[6-2*i], 1'b1, 1'b0, r, 1'b0);
   endtask

   // Per-cycle state check against the model after each posedge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         chk("dout_valid", 32'(dout_valid), 32'(m_valid));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("dout", 32'(dout), 32'(m_dout));
      end
   end

   // Scoreboard monitor: compares each word the consumer actually accepts.
   initial begin
      logic [W-1:0] exp_w;
      forever begin
         @(negedge clk);
         #3;
         if (!rst && dout_valid && dout_ready) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_word", 32'(dout), 32'hFFFF_FFFF);
            end else begin
               exp_w = sb.pop_front();
               chk("sb_word", 32'(dout), 32'(exp_w));
            end
         end
      end
   end

   initial begin
      // Basic word
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 0);
      send_word(8'hB2, 1'b1);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);

      // Backpressure and overflow
      send_word(8'hB2, 1'b0);
      send_word(8'h5A, 1'b0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);

      // Simultaneous accept and load
      cyc(0, 0, 0, 0, 0, 1);
      send_word(8'hB2, 1'b0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(1, 1, 1, 0, 0, 0);
      cyc(1, 1, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);

      // en gaps with din toggling
      cyc(1, 0, 1, 0, 1, 0);
      cyc(1, 1, 1, 0, 1, 0);
      cyc(0, 1, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 1, 0);
      cyc(0, 1, 0, 0, 1, 0);
      cyc(0, 0, 1, 0, 1, 0);
      cyc(1, 0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);

      // align mid-word
      cyc(1, 1, 1, 0, 1, 0);
      cyc(1, 1, 1, 0, 1, 0);
      cyc(1, 1, 1, 1, 1, 0);
      send_word(8'h81, 1'b1);
      cyc(0, 0, 0, 0, 1, 0);

      // Reset mid-operation
      send_word(8'hB2, 1'b0);
      cyc(1, 0, 1, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 0);
      cyc(1, 1, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      send_word(8'hC5, 1'b1);
      cyc(0, 0, 0, 0, 1, 0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 19) == 0),
             1'($urandom),
             ($urandom_range(0, 49) == 0));
      end

      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #2;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
